// File: rtl/input_debouncer.sv
// Synchroniser plus debounce filter: sig_out follows sig_in once the synced level has held for DEBOUNCE_CYCLES clocks.
// Optional glitch counter is enabled by defining DEBOUNCE_GLITCH_CNT_EN.
module input_debouncer #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig_in,
  output logic       sig_out,
  output logic       busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE,
    QUALIFY
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       next_cnt;
  logic                   next_out;
  logic                   glitch;
  logic                   s;
  state_t                 state;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
    end
  end

  // The stability counter doubles as the state: any nonzero count means a change is being qualified.
  always_comb begin
    state = (cnt == '0) ? STABLE : QUALIFY;
  end

  always_comb begin
    next_cnt = cnt;
    next_out = sig_out;
    glitch   = 1'b0;
    if (s == sig_out) begin
      next_cnt = '0;
      glitch   = (state == QUALIFY);
    end else if (cnt == CNT_LAST) begin
      next_out = s;
      next_cnt = '0;
    end else begin
      next_cnt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      sig_out <= RST_VAL;
      busy    <= 1'b0;
    end else begin
      cnt     <= next_cnt;
      sig_out <= next_out;
      busy    <= (next_cnt != '0);
    end
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  // Saturating count of qualifications abandoned because the input fell back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      glitch_cnt <= 8'd0;
    end else if (glitch && (glitch_cnt != 8'hFF)) begin
      glitch_cnt <= glitch_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer (S=2, D=4, RST_VAL=0); glitch checks only when DEBOUNCE_GLITCH_CNT_EN is defined.
`timescale 1ns/1ps
module tb_input_debouncer;

  typedef struct {
    string tag;
    logic  exp_out;
    logic  exp_busy;
    bit    chk_busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sig_in = 1'b1;
  logic sig_out;
  logic busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  input_debouncer #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .RST_VAL(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sig_in(sig_in),
    .sig_out(sig_out),
    .busy(busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one clock's inputs at the falling edge and queue what the next rising edge must produce.
  task automatic applyStimulus(input logic rst_level, input logic level, input string tag,
                               input logic exp_out, input logic exp_busy, input bit chk_busy);
    exp_t e;
    @(negedge clk);
    rst    = rst_level;
    sig_in = level;
    e.tag = tag;
    e.exp_out = exp_out;
    e.exp_busy = exp_busy;
    e.chk_busy = chk_busy;
    exp_q.push_back(e);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput({e.tag, "_out"}, {7'd0, sig_out}, {7'd0, e.exp_out});
      if (e.chk_busy) checkOutput({e.tag, "_busy"}, {7'd0, busy}, {7'd0, e.exp_busy});
    end
  end

  task automatic checkGlitch(input string tag, input logic [7:0] expected);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    checkOutput(tag, glitch_cnt, expected);
`endif
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario order: reset hold, short glitch, rise, fall, reset mid-qualify, glitch saturation.
  initial begin
    #1;
    checkGlitch("s1_glitch_start", 8'd0);
    for (int k = 1; k <= 5; k++)
      applyStimulus(1'b0, 1'b1, $sformatf("s1_k%0d", k), 1'b0, 1'b0, 1'b1);
    checkGlitch("s1_glitch", 8'd0);

    for (int k = 1; k <= 4; k++)
      applyStimulus(1'b1, 1'b0, $sformatf("idle_k%0d", k), 1'b0, 1'b0, 1'b1);

    for (int k = 1; k <= 10; k++)
      applyStimulus(1'b1, (k <= 2), $sformatf("s3_k%0d", k), 1'b0, (k == 3 || k == 4), 1'b1);
    @(negedge clk);
    checkGlitch("s3_glitch", 8'd1);

    for (int k = 1; k <= 20; k++)
      applyStimulus(1'b1, 1'b1, $sformatf("s2_k%0d", k), (k >= 6), (k >= 3 && k <= 5), 1'b1);

    for (int k = 1; k <= 20; k++)
      applyStimulus(1'b1, 1'b0, $sformatf("s4_k%0d", k), (k < 6), (k >= 3 && k <= 5), 1'b1);
    @(negedge clk);
    checkGlitch("s4_glitch", 8'd1);

    for (int k = 1; k <= 3; k++)
      applyStimulus(1'b1, 1'b1, $sformatf("s5pre_k%0d", k), 1'b0, (k == 3), 1'b1);
    applyStimulus(1'b0, 1'b1, "s5_rst", 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("s5_async_out", {7'd0, sig_out}, 8'd0);
    checkOutput("s5_async_busy", {7'd0, busy}, 8'd0);
    checkGlitch("s5_async_glitch", 8'd0);
    for (int k = 1; k <= 10; k++)
      applyStimulus(1'b1, 1'b1, $sformatf("s5_k%0d", k), (k >= 6), (k >= 3 && k <= 5), 1'b1);

    for (int k = 1; k <= 2; k++)
      applyStimulus(1'b0, 1'b0, $sformatf("s6rst_k%0d", k), 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++)
      applyStimulus(1'b1, 1'b0, $sformatf("s6idle_k%0d", k), 1'b0, 1'b0, 1'b1);
    for (int b = 1; b <= 300; b++) begin
      for (int k = 1; k <= 4; k++)
        applyStimulus(1'b1, (k <= 2), $sformatf("s6_b%0d_k%0d", b, k), 1'b0, 1'b0, 1'b0);
      if (b == 100 || b == 300) begin
        for (int k = 1; k <= 4; k++)
          applyStimulus(1'b1, 1'b0, $sformatf("s6settle_b%0d_k%0d", b, k), 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkGlitch($sformatf("s6_glitch_b%0d", b), (b == 100) ? 8'd100 : 8'd255);
      end
    end

    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
